// File: rtl/alu_share_pkg.sv
// Shared types for the ALU share arbiter: ALU opcodes, FSM states, pointer helper.
package alu_share_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD   = 2'b00;
    localparam alu_op_t OP_PASS1 = 2'b01;
    localparam alu_op_t OP_PASS2 = 2'b10;
    localparam alu_op_t OP_XOR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RESP
    } arb_state_t;

    localparam int HOLD_CW = 4;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDW'((int'(ptr) + i) % NREQ);
            if (!any && valid[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NREQ requesters with round-robin grant and held operands.
// Define ALU_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int ALU_LAT = 2,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_opcode,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [1:0]          alu_opcode,
    output logic [W-1:0]        alu_i1,
    output logic [W-1:0]        alu_i2,
    input  logic [W-1:0]        alu_o1,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data,
    input  logic                rsp_ready,
    output logic                busy
);

    arb_state_t          state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HOLD_CW-1:0]  hold_cnt_q, hold_cnt_d;
    alu_op_t             alu_opcode_q, alu_opcode_d;
    logic [W-1:0]        alu_i1_q, alu_i1_d, alu_i2_q, alu_i2_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [W-1:0]        rsp_data_q, rsp_data_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]     rr_grant, grant;
    logic [IDW-1:0]      rr_idx, gidx;
    logic                rr_any, prio_hit;
    alu_op_t             sel_op;
    logic [W-1:0]        sel_a, sel_b;
    logic                hs;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

`ifdef ALU_ARB_PRIO0_EN
    assign prio_hit = req_valid[0];
    assign grant    = prio_hit ? NREQ'(1) : rr_grant;
    assign gidx     = prio_hit ? '0 : rr_idx;
`else
    assign prio_hit = 1'b0;
    assign grant    = rr_grant;
    assign gidx     = rr_idx;
`endif

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign hs        = |req_ready;

    always_comb begin
        sel_op = OP_ADD;
        sel_a  = '0;
        sel_b  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_op = req_opcode[2*k +: 2];
                sel_a  = req_a[W*k +: W];
                sel_b  = req_b[W*k +: W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_i1_d     = alu_i1_q;
        alu_i2_d     = alu_i2_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    alu_opcode_d = sel_op;
                    alu_i1_d     = sel_a;
                    alu_i2_d     = sel_b;
                    rsp_id_d     = gidx;
                    hold_cnt_d   = HOLD_CW'(ALU_LAT - 1);
                    state_d      = HOLD;
                    // Priority grants to requester 0 leave the rotation untouched.
                    if (!prio_hit)
                        rr_ptr_d = IDW'(wrap_inc(int'(gidx), NREQ));
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    rsp_data_d  = alu_o1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
            alu_opcode_q <= OP_ADD;
            alu_i1_q     <= '0;
            alu_i2_q     <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_i1_q     <= alu_i1_d;
            alu_i2_q     <= alu_i2_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_i1     = alu_i1_q;
    assign alu_i2     = alu_i2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the datapath side.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [2*NREQ-1:0]   req_opcode;
    logic [W*NREQ-1:0]   req_a, req_b;
    logic [1:0]          alu_opcode;
    logic [W-1:0]        alu_i1, alu_i2, alu_o1;
    logic                rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_data;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter #(.NREQ(NREQ), .W(W), .ALU_LAT(2), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_opcode (alu_opcode),
        .alu_i1     (alu_i1),
        .alu_i2     (alu_i2),
        .alu_o1     (alu_o1),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            2'b00:   alu_o1 = alu_i1 + alu_i2;
            2'b01:   alu_o1 = alu_i1;
            2'b10:   alu_o1 = alu_i2;
            default: alu_o1 = alu_i1 ^ alu_i2;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  32'(req_ready),  32'h0);
        check({tag, "_op"},   32'(alu_opcode), 32'h0);
        check({tag, "_i1"},   32'(alu_i1),     32'h0);
        check({tag, "_i2"},   32'(alu_i2),     32'h0);
        check({tag, "_rv"},   32'(rsp_valid),  32'h0);
        check({tag, "_id"},   32'(rsp_id),     32'h0);
        check({tag, "_data"}, 32'(rsp_data),   32'h0);
        check({tag, "_busy"}, 32'(busy),       32'h0);
    endtask

    // Hand-computed result per requester for the operand set used in the rotation tests.
    logic [7:0] data_of [4] = '{8'h03, 8'h11, 8'h44, 8'hA5};
`ifdef ALU_ARB_PRIO0_EN
    int exp_id [5] = '{0, 0, 0, 0, 0};
`else
    int exp_id [5] = '{0, 1, 2, 3, 0};
`endif

    initial begin
        rst = 1'b1; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick; tick;
        check_reset_vals("reset");
        rst = 1'b0;
        tick;

        // Single request from requester 1: 12 + 34
        req_opcode = 8'h00; req_a = 32'h0000_1200; req_b = 32'h0000_3400; req_valid = 4'b0010;
        #1 check("s_rdy", 32'(req_ready), 32'h2);
        tick;
        req_valid = '0; req_a = '0; req_b = '0;
        check("s_busy", 32'(busy), 32'h1);
        check("s_rdy_hold", 32'(req_ready), 32'h0);
        check("s_i1_t1", 32'(alu_i1), 32'h12);
        check("s_i2_t1", 32'(alu_i2), 32'h34);
        check("s_rv_t1", 32'(rsp_valid), 32'h0);
        tick;
        check("s_i1_t2", 32'(alu_i1), 32'h12);
        check("s_rv_t2", 32'(rsp_valid), 32'h0);
        tick;
        check("s_rv_t3", 32'(rsp_valid), 32'h1);
        check("s_id", 32'(rsp_id), 32'h1);
        check("s_data", 32'(rsp_data), 32'h46);
        check("s_i1_t3", 32'(alu_i1), 32'h12);
        check("s_i2_t3", 32'(alu_i2), 32'h34);
        rsp_ready = 1'b1;
        tick;
        check("s_rv_done", 32'(rsp_valid), 32'h0);
        check("s_busy_done", 32'(busy), 32'h0);

        // All four requesters valid continuously from rr_ptr=0
        rst = 1'b1; tick; rst = 1'b0;
        req_opcode = 8'b11_10_01_00;
        req_a = {8'h5A, 8'h33, 8'h11, 8'h01};
        req_b = {8'hFF, 8'h44, 8'h22, 8'h02};
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1 check("rr_rdy", 32'(req_ready), 32'(1) << exp_id[n]);
            tick;
            check("rr_op", 32'(alu_opcode), 32'(exp_id[n]));
            check("rr_rdy_hold", 32'(req_ready), 32'h0);
            tick; tick;
            check("rr_rv", 32'(rsp_valid), 32'h1);
            check("rr_id", 32'(rsp_id), 32'(exp_id[n]));
            check("rr_data", 32'(rsp_data), 32'(data_of[exp_id[n]]));
            tick;
        end

        // Back-pressure in RESP; rr_ptr is 1 here
        rsp_ready = 1'b0; req_valid = 4'b0100;
        #1 check("bp_rdy", 32'(req_ready), 32'h4);
        tick;
        req_valid = 4'b0110;
        tick; tick;
        for (int n = 0; n < 5; n++) begin
            check("bp_rv", 32'(rsp_valid), 32'h1);
            check("bp_id", 32'(rsp_id), 32'h2);
            check("bp_data", 32'(rsp_data), 32'h44);
            check("bp_rdy_resp", 32'(req_ready), 32'h0);
            tick;
        end
        rsp_ready = 1'b1;
        #1 check("bp_rdy_release", 32'(req_ready), 32'h0);
        tick;
        check("bp_rv_clear", 32'(rsp_valid), 32'h0);
        check("bp_next_rdy", 32'(req_ready), 32'h2);
        tick; tick; tick;
        check("bp2_id", 32'(rsp_id), 32'h1);
        check("bp2_data", 32'(rsp_data), 32'h11);
        req_valid = '0;
        tick;

`ifndef ALU_ARB_PRIO0_EN
        // Wrap: rr_ptr is 2, grant 3 then 0
        req_valid = 4'b1001;
        #1 check("w_rdy3", 32'(req_ready), 32'h8);
        tick; tick; tick;
        check("w_id3", 32'(rsp_id), 32'h3);
        check("w_data3", 32'(rsp_data), 32'hA5);
        tick;
        check("w_rdy0", 32'(req_ready), 32'h1);
        tick; tick; tick;
        check("w_id0", 32'(rsp_id), 32'h0);
        check("w_data0", 32'(rsp_data), 32'h03);
        tick;
        req_valid = 4'hF;
        #1 check("w_ptr1", 32'(req_ready), 32'h2);
`else
        req_valid = 4'hF;
        #1 check("p_rdy0", 32'(req_ready), 32'h1);
`endif

        // Reset one cycle after the handshake
        tick;
        req_valid = '0;
        check("rh_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick;
        check_reset_vals("rh");
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("rh_no_rsp", 32'(rsp_valid), 32'h0);
            tick;
        end
        req_valid = 4'hF;
        #1 check("rh_rdy", 32'(req_ready), 32'h1);
        tick;
        req_valid = '0;
        tick; tick;
        check("rh_rv", 32'(rsp_valid), 32'h1);
        check("rh_id", 32'(rsp_id), 32'h0);
        check("rh_data", 32'(rsp_data), 32'h03);
        tick;
        check("rh_rv_done", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU (2-bit opcode: 00 add, 01 pass i1, 10 pass i2, 11 xor) among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Registers the operands and opcode and holds them stable for ALU_LAT cycles so the ALU's path delays settle.
- Returns the result with the requester ID over a valid/ready response channel. Sits between the issuing masters and the ALU datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width
- ALU_LAT, 2, cycles operands are held before the result is sampled (1..15)
- IDW, 2, requester ID width, must equal clog2(NREQ)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_opcode  in  2*NREQ  packed opcodes, requester k at [2k+1:2k]
- req_a  in  W*NREQ  packed operand i1
- req_b  in  W*NREQ  packed operand i2
- alu_opcode  out  2  to ALU opcode
- alu_i1  out  W  to ALU i1
- alu_i2  out  W  to ALU i2
- alu_o1  in  W  from ALU o1
- rsp_valid  out  1  result valid
- rsp_id  out  IDW  requester that issued the result
- rsp_data  out  W  result
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, alu_opcode=0, alu_i1=0, alu_i2=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- States: IDLE -> HOLD -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: one-hot grant to the first valid requester at or after rr_ptr, searching upward with wrap.
  - req_ready=0 when no request is valid.
  - On handshake (valid&ready) from requester g: latch its opcode/a/b into alu_* and g into rsp_id; set hold_cnt=ALU_LAT-1; go to HOLD.
  - rr_ptr <= (g+1) mod NREQ.
- HOLD:
  - req_ready=0; alu_* outputs held constant.
  - When hold_cnt==0: rsp_data <= alu_o1, rsp_valid <= 1, go to RESP. Otherwise decrement hold_cnt.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data held until rsp_ready.
  - On rsp_ready: rsp_valid <= 0 and go to IDLE.
  - The next grant is earliest the cycle after return to IDLE; no bypass from RESP.
- Latency: handshake at cycle T gives rsp_valid high at cycle T+ALU_LAT+1 (T+3 with defaults). Minimum issue interval is ALU_LAT+2 cycles.
- rr_ptr advances only on grant, never while idle.
- A requester that drops req_valid without a grant is simply skipped; no state is kept for it.
- Simultaneous requests from all NREQ requesters: served in rotating order starting at rr_ptr.
- Opcode 11 is passed through unchanged; the result is whatever the ALU produces.
- rst mid-operation: abort immediately, return to the reset values, discard any pending result (it is never presented).
- alu_* outputs change only in the IDLE-handshake cycle or on reset.

Optional Feature:
- ALU_ARB_PRIO0_EN defined: requester 0 has strict priority. If req_valid[0]=1 in IDLE it is granted regardless of rr_ptr, and rr_ptr is not updated. Other requesters stay round-robin among themselves.
- Not defined: pure round-robin as above.

Decomposition:
- Package alu_share_pkg holds:
  - typedef alu_op_t (2-bit) with constants OP_ADD=2'b00, OP_PASS1=2'b01, OP_PASS2=2'b10, OP_XOR=2'b11
  - state enum arb_state_t {IDLE, HOLD, RESP}
- Sub-module rr_pick: combinational, takes NREQ valids and a pointer and returns the one-hot grant and encoded index. The top-level FSM and operand registers are in alu_share_arbiter.

Test Plan:
- Single request: req_valid=4'b0010, opcode 00, a=8'h12, b=8'h34, ALU model returns a+b -> rsp_valid at T+3, rsp_id=1, rsp_data=8'h46; alu_i1/i2 stable T+1..T+3.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; responses carry ids 0,1,2,3,0; issue interval 4 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready=0 throughout; the next grant comes 1 cycle after rsp_ready=1.
- Wrap: after a grant to requester 3 with req_valid=4'b1001 -> next grant goes to requester 0; rr_ptr=1 afterwards.
- Reset in HOLD (rst=1 one cycle after the handshake) -> next cycle all outputs are at reset values, no rsp_valid ever appears, and the next request is granted normally starting from rr_ptr=0.
- With ALU_ARB_PRIO0_EN and req_valid=4'b0111, rr_ptr=1 -> requester 0 is granted three times in a row while it stays valid. Requesters 1 and 2 are granted only when req_valid[0]=0.
